// File: rtl/io_pins_fpga_bus.sv
`default_nettype none
// ============================================================================
// io_pins_fpga_bus : MCU register bridge onto banked, bidirectional GPIO pins
// Revision 1.0
// ============================================================================
module io_pins_fpga_bus #(
   parameter int PINS_COUNT = 132,
   parameter int NUM_BANKS  = (PINS_COUNT + 7) / 8
) (
   input  logic                  CLK50,
   input  logic                  rst_n,
   inout  wire  [7:0]            data,
   input  logic [7:0]            address,
   input  logic                  mcu_mstr,
   input  logic                  write_enable,
   output logic                  fpga_ready,
   inout  wire  [PINS_COUNT-1:0] io_pins
);

   localparam int                  REG_BITS   = NUM_BANKS * 8;
   localparam logic [REG_BITS-1:0] VALID_MASK = {REG_BITS{1'b1}} >> (REG_BITS - PINS_COUNT);
   localparam logic [7:0]          ID_VALUE   = 8'hA5;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic                  mstr_meta_q, mstr_sync_q;
   logic [PINS_COUNT-1:0] pin_meta_q, pin_sync_q;
   logic [REG_BITS-1:0]   out_q, out_d, dir_q, dir_d;
   logic [REG_BITS-1:0]   in_ext;
   logic [7:0]            rdata_q, rdata_d;
   logic [7:0]            rd_mux;
   logic                  accept;

   always_ff @(posedge CLK50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mstr_meta_q <= 1'b0;
         mstr_sync_q <= 1'b0;
         pin_meta_q  <= '0;
         pin_sync_q  <= '0;
         out_q       <= '0;
         dir_q       <= '0;
         rdata_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         mstr_meta_q <= mcu_mstr;
         mstr_sync_q <= mstr_meta_q;
         pin_meta_q  <= io_pins;
         pin_sync_q  <= pin_meta_q;
         out_q       <= out_d;
         dir_q       <= dir_d;
         rdata_q     <= rdata_d;
      end
   end

   // Staying in ACK while the strobe is high gives exactly one access per strobe.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mstr_sync_q)  state_d = ST_ACK;
         ST_ACK:  if (!mstr_sync_q) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      accept     = (state_q == ST_IDLE) && mstr_sync_q;
      fpga_ready = (state_q == ST_ACK);
   end

   always_comb begin
      in_ext                 = '0;
      in_ext[PINS_COUNT-1:0] = pin_sync_q;
   end

   always_comb begin
      rd_mux = 8'h00;
      if (address == 8'h7F) rd_mux = ID_VALUE;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (address == 8'(k))      rd_mux = out_q[k*8 +: 8];
         if (address == 8'(32 + k)) rd_mux = dir_q[k*8 +: 8];
         if (address == 8'(64 + k)) rd_mux = in_ext[k*8 +: 8];
      end
   end

   // Bits beyond the last pin are masked on write so they always read back 0.
   always_comb begin
      out_d   = out_q;
      dir_d   = dir_q;
      rdata_d = rdata_q;
      if (accept) begin
         if (write_enable) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
               if (address == 8'(k))      out_d[k*8 +: 8] = data & VALID_MASK[k*8 +: 8];
               if (address == 8'(32 + k)) dir_d[k*8 +: 8] = data & VALID_MASK[k*8 +: 8];
            end
         end else begin
            rdata_d = rd_mux;
         end
      end
   end

   assign data = (mcu_mstr && !write_enable && fpga_ready) ? rdata_q : 8'hzz;

   for (genvar n = 0; n < PINS_COUNT; n++) begin : g_pin
      assign io_pins[n] = dir_q[n] ? out_q[n] : 1'bz;
   end

endmodule
`default_nettype wire

// File: tb/tb_io_pins_fpga_bus.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_io_pins_fpga_bus : randomized MCU transactions against a register-map model
// Revision 1.0
// ============================================================================
module tb_io_pins_fpga_bus;

   localparam int PINS  = 132;
   localparam int BANKS = 17;

   logic            CLK50        = 1'b0;
   logic            rst_n        = 1'b0;
   wire  [7:0]      data;
   logic [7:0]      address      = 8'h00;
   logic            mcu_mstr     = 1'b0;
   logic            write_enable = 1'b0;
   logic            fpga_ready;
   wire  [PINS-1:0] io_pins;

   logic [7:0]      tb_data    = 8'h00;
   logic            tb_data_en = 1'b0;
   logic [PINS-1:0] pin_val    = '0;
   logic [PINS-1:0] pin_en     = '0;

   int n_checks = 0;
   int n_pass   = 0;

   byte unsigned out_m[BANKS];
   byte unsigned dir_m[BANKS];

   io_pins_fpga_bus #(.PINS_COUNT(PINS), .NUM_BANKS(BANKS)) dut (
      .CLK50        (CLK50),
      .rst_n        (rst_n),
      .data         (data),
      .address      (address),
      .mcu_mstr     (mcu_mstr),
      .write_enable (write_enable),
      .fpga_ready   (fpga_ready),
      .io_pins      (io_pins)
   );

   always #10 CLK50 = ~CLK50;

   // Weak pull-ups make an undriven line observable as a 1.
   assign data = tb_data_en ? tb_data : 8'hzz;
   for (genvar i = 0; i < 8; i++) begin : g_data_pu
      pullup pu (data[i]);
   end
   for (genvar i = 0; i < PINS; i++) begin : g_pin_tb
      assign io_pins[i] = pin_en[i] ? pin_val[i] : 1'bz;
      pullup pu (io_pins[i]);
   end

   task automatic check_eq(input string tag, input logic [PINS-1:0] got, input logic [PINS-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %h required %h", tag, got, exp);
   endtask

   function automatic byte unsigned bank_mask(input int k);
      byte unsigned m = 8'h00;
      for (int b = 0; b < 8; b++) if (k * 8 + b < PINS) m[b] = 1'b1;
      return m;
   endfunction

   function automatic logic [PINS-1:0] dir_vec();
      logic [PINS-1:0] r = '0;
      for (int n = 0; n < PINS; n++) r[n] = dir_m[n / 8][n % 8];
      return r;
   endfunction

   // Level each pin settles to: our own drive wins, else the bench drive, else pull-up.
   function automatic logic [PINS-1:0] pins_exp();
      logic [PINS-1:0] r = '0;
      for (int n = 0; n < PINS; n++)
         r[n] = dir_m[n / 8][n % 8] ? out_m[n / 8][n % 8] : (pin_en[n] ? pin_val[n] : 1'b1);
      return r;
   endfunction

   function automatic logic [7:0] reg_exp(input int a);
      logic [PINS-1:0] p;
      logic [7:0]      r = 8'h00;
      if (a < BANKS) return out_m[a];
      if (a >= 32 && a < 32 + BANKS) return dir_m[a - 32];
      if (a >= 64 && a < 64 + BANKS) begin
         p = pins_exp();
         for (int b = 0; b < 8; b++)
            if ((a - 64) * 8 + b < PINS) r[b] = p[(a - 64) * 8 + b];
         return r;
      end
      if (a == 127) return 8'hA5;
      return 8'h00;
   endfunction

   task automatic model_write(input int a, input logic [7:0] d);
      if (a < BANKS) out_m[a] = d & bank_mask(a);
      else if (a >= 32 && a < 32 + BANKS) dir_m[a - 32] = d & bank_mask(a - 32);
   endtask

   task automatic model_reset();
      for (int k = 0; k < BANKS; k++) begin
         out_m[k] = 8'h00;
         dir_m[k] = 8'h00;
      end
   endtask

   function automatic logic [PINS-1:0] rand_vec();
      logic [159:0] r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return r[PINS-1:0];
   endfunction

   task automatic txn(input bit we, input logic [7:0] addr, input logic [7:0] wd, input int hold);
      int         cyc;
      int         hi;
      logic [7:0] exp_rd;
      // Release any bench drive on pins this write is about to turn into outputs.
      if (we && addr >= 32 && addr < 32 + BANKS)
         for (int b = 0; b < 8; b++)
            if ((addr - 32) * 8 + b < PINS && wd[b]) pin_en[(addr - 32) * 8 + b] = 1'b0;
      exp_rd = reg_exp(int'(addr));
      @(posedge CLK50); #1;
      address      = addr;
      write_enable = we;
      tb_data      = wd;
      tb_data_en   = we;
      mcu_mstr     = 1'b1;
      cyc = 0;
      while (fpga_ready !== 1'b1 && cyc < 10) begin
         @(posedge CLK50); #1;
         cyc++;
      end
      check_eq("ready_rise_latency", cyc, 3);
      if (we) model_write(int'(addr), wd);
      else    check_eq($sformatf("read_%02h", addr), data, exp_rd);
      if (hold > 0) begin
         hi = 0;
         repeat (hold) begin
            @(posedge CLK50); #1;
            if (fpga_ready === 1'b1) hi++;
         end
         check_eq("ready_held", hi, hold);
      end
      mcu_mstr   = 1'b0;
      tb_data_en = 1'b0;
      #1;
      check_eq("data_z_after_drop", data, 8'hFF);
      cyc = 0;
      while (fpga_ready !== 1'b0 && cyc < 10) begin
         @(posedge CLK50); #1;
         cyc++;
      end
      check_eq("ready_fall_latency", cyc, 3);
      check_eq("pins", io_pins, pins_exp());
   endtask

   task automatic rd(input logic [7:0] addr);
      txn(1'b0, addr, 8'h00, 0);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] d);
      txn(1'b1, addr, d, 0);
   endtask

   initial begin
      int         cyc;
      int         sel;
      logic [7:0] a;
      model_reset();
      repeat (3) @(posedge CLK50);
      #1;
      check_eq("reset_ready", fpga_ready, 1'b0);
      check_eq("reset_pins_z", io_pins, {PINS{1'b1}});
      check_eq("reset_data_z", data, 8'hFF);
      rst_n = 1'b1;

      rd(8'h00); rd(8'h20); rd(8'h7F);

      wr(8'h20, 8'hFF); wr(8'h00, 8'h5A);
      check_eq("pins_7_0", io_pins[7:0], 8'h5A);
      rd(8'h40);

      wr(8'h22, 8'h00);
      pin_val[23:16] = 8'hC3;
      pin_en[23:16]  = 8'hFF;
      repeat (3) @(posedge CLK50);
      rd(8'h42);

      wr(8'h30, 8'hFF); wr(8'h10, 8'hFF);
      check_eq("pins_131_128", io_pins[131:128], 4'hF);
      rd(8'h30); rd(8'h10); rd(8'h50);

      wr(8'h45, 8'h77); wr(8'h60, 8'h77);
      rd(8'h60); rd(8'h45); rd(8'h00);

      txn(1'b1, 8'h01, 8'h99, 20);
      rd(8'h01);

      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            pin_val = rand_vec();
            pin_en  = rand_vec() & ~dir_vec();
         end
         sel = $urandom_range(0, 9);
         if (sel <= 2)      a = 8'($urandom_range(0, BANKS - 1));
         else if (sel <= 5) a = 8'(32 + $urandom_range(0, BANKS - 1));
         else if (sel <= 7) a = 8'(64 + $urandom_range(0, BANKS - 1));
         else if (sel == 8) a = 8'h7F;
         else               a = 8'($urandom_range(0, 255));
         txn(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), 0);
      end

      // Reset in the middle of an acknowledged write, strobe left high across release.
      pin_en = '0;
      wr(8'h21, 8'hFF);
      @(posedge CLK50); #1;
      address      = 8'h01;
      write_enable = 1'b1;
      tb_data      = 8'h3C;
      tb_data_en   = 1'b1;
      mcu_mstr     = 1'b1;
      cyc = 0;
      while (fpga_ready !== 1'b1 && cyc < 10) begin
         @(posedge CLK50); #1;
         cyc++;
      end
      check_eq("pre_reset_ready_latency", cyc, 3);
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("async_reset_ready", fpga_ready, 1'b0);
      check_eq("async_reset_pins_z", io_pins, {PINS{1'b1}});
      repeat (2) @(posedge CLK50);
      #1 rst_n = 1'b1;
      cyc = 0;
      while (fpga_ready !== 1'b1 && cyc < 10) begin
         @(posedge CLK50); #1;
         cyc++;
      end
      check_eq("post_reset_accept_latency", cyc, 3);
      model_write(1, 8'h3C);
      mcu_mstr   = 1'b0;
      tb_data_en = 1'b0;
      cyc = 0;
      while (fpga_ready !== 1'b0 && cyc < 10) begin
         @(posedge CLK50); #1;
         cyc++;
      end
      check_eq("post_reset_fall_latency", cyc, 3);
      rd(8'h01); rd(8'h21); rd(8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
